// File: rtl/serial_adder_stream.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock,
// LSB digit first, through one DIGIT-bit adder slice and a registered carry.
module serial_adder_stream #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;

    logic [WIDTH-1:0] w_bp;
    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_res_shift;

    // Subtraction is a + ~b + 1; the borrow-in folds into the initial carry.
    assign w_bp   = sub ? ~b : b;
    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
    assign w_res_shift = WIDTH'({w_dsum[DIGIT-1:0], r_res} >> DIGIT);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)         w_next = RUN;
            RUN:     if (r_cnt == LAST)    w_next = DONE;
            DONE:    if (out_ready)        w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a     <= a;
                    r_b     <= w_bp;
                    r_c     <= sub ^ carry_in;
                    r_a_msb <= a[WIDTH-1];
                    r_b_msb <= w_bp[WIDTH-1];
                    r_cnt   <= '0;
                end
                RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_c   <= w_dsum[DIGIT];
                    r_res <= w_res_shift;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_res;
    assign carry_out = r_c;
    // Like-signed operands producing an opposite-signed result.
    assign overflow  = (r_a_msb == r_b_msb) && (r_res[WIDTH-1] != r_a_msb);

endmodule
